// File: rtl/monoflop_sync_multi.sv
// Multi-channel synchronised monoflop: edge-triggered pulses of programmable
// width followed by a programmable dead time, with per-channel missed-edge counters.
module monoflop_sync_multi #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH_BITS  = 8,
  parameter int COUNT_BITS  = 16,
  parameter int RETRIGGER   = 0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [CHANNELS-1:0]            trigger,
  input  logic [CHANNELS-1:0]            enable,
  input  logic [1:0]                     edge_mode,
  input  logic [WIDTH_BITS-1:0]          pulse_width,
  input  logic [WIDTH_BITS-1:0]          holdoff,
  input  logic                           clear_missed,
  output logic [CHANNELS-1:0]            q,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS*COUNT_BITS-1:0] missed
);

  localparam int                    SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic                  RETRIG_EN = (RETRIGGER != 0);
  localparam logic [WIDTH_BITS-1:0] W_ONE     = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] C_ONE     = COUNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prv);
    logic hit;
    case (mode)
      2'b00:   hit = cur & ~prv;
      2'b01:   hit = ~cur & prv;
      2'b10:   hit = cur ^ prv;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] val);
    logic [COUNT_BITS-1:0] res;
    if (&val) begin
      res = val;
    end else begin
      res = val + C_ONE;
    end
    return res;
  endfunction

  logic [WIDTH_BITS-1:0] width_eff_s;

  // A programmed width of zero still yields a one-clock pulse.
  always_comb begin
    if (pulse_width == '0) begin
      width_eff_s = W_ONE;
    end else begin
      width_eff_s = pulse_width;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_N-1:0]     sync_r;
    logic                  prev_r;
    logic                  edge_s;
    logic                  miss_s;
    state_t                state_r, state_nxt_s;
    logic [WIDTH_BITS-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH_BITS-1:0] hold_r, hold_nxt_s;
    logic                  q_r, q_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic [COUNT_BITS-1:0] missed_r, missed_nxt_s;

    // Synchroniser chain plus the previous-level flop used for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync_r <= '0;
        prev_r <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_N-2:0], trigger[ch]};
        prev_r <= sync_r[SYNC_N-1];
      end
    end

    assign edge_s = edge_hit(edge_mode, sync_r[SYNC_N-1], prev_r);

    // Channel FSM next-state, counter and output decode
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      hold_nxt_s  = hold_r;
      q_nxt_s     = q_r;
      busy_nxt_s  = busy_r;
      miss_s      = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (edge_s && enable[ch]) begin
            state_nxt_s = ST_PULSE;
            cnt_nxt_s   = width_eff_s;
            hold_nxt_s  = holdoff;
            q_nxt_s     = 1'b1;
            busy_nxt_s  = 1'b1;
          end else begin
            q_nxt_s     = 1'b0;
            busy_nxt_s  = 1'b0;
          end
        end
        ST_PULSE: begin
          // A retrigger takes precedence over expiry so q never glitches low.
          if (edge_s && enable[ch] && RETRIG_EN) begin
            cnt_nxt_s = width_eff_s;
          end else if (cnt_r == W_ONE) begin
            q_nxt_s = 1'b0;
            if (hold_r != '0) begin
              state_nxt_s = ST_HOLDOFF;
              cnt_nxt_s   = hold_r;
              busy_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_IDLE;
              busy_nxt_s  = 1'b0;
            end
          end else begin
            cnt_nxt_s = cnt_r - W_ONE;
          end
          miss_s = edge_s && enable[ch] && !RETRIG_EN;
        end
        ST_HOLDOFF: begin
          if (cnt_r == W_ONE) begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r - W_ONE;
          end
          q_nxt_s = 1'b0;
          miss_s  = edge_s && enable[ch];
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          q_nxt_s     = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      endcase

      if (clear_missed) begin
        missed_nxt_s = '0;
      end else if (miss_s) begin
        missed_nxt_s = sat_inc(missed_r);
      end else begin
        missed_nxt_s = missed_r;
      end
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_r  <= ST_IDLE;
        cnt_r    <= '0;
        hold_r   <= '0;
        q_r      <= 1'b0;
        busy_r   <= 1'b0;
        missed_r <= '0;
      end else begin
        state_r  <= state_nxt_s;
        cnt_r    <= cnt_nxt_s;
        hold_r   <= hold_nxt_s;
        q_r      <= q_nxt_s;
        busy_r   <= busy_nxt_s;
        missed_r <= missed_nxt_s;
      end
    end

    assign q[ch]                              = q_r;
    assign busy[ch]                           = busy_r;
    assign missed[ch*COUNT_BITS +: COUNT_BITS] = missed_r;
  end

endmodule

// File: tb/tb_monoflop_sync_multi.sv
// Directed bench for monoflop_sync_multi: a non-retriggering default instance
// and a retriggering instance with 2-bit counters share all inputs.
module tb_monoflop_sync_multi;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   trigger;
  logic [7:0]   enable;
  logic [1:0]   edge_mode;
  logic [7:0]   pulse_width;
  logic [7:0]   holdoff;
  logic         clear_missed;
  logic [7:0]   q_a, busy_a, q_b, busy_b;
  logic [127:0] missed_a;
  logic [15:0]  missed_b;

  int vectors = 0;
  int errors  = 0;

  monoflop_sync_multi dut (
    .clock(clock), .reset_n(reset_n), .trigger(trigger), .enable(enable),
    .edge_mode(edge_mode), .pulse_width(pulse_width), .holdoff(holdoff),
    .clear_missed(clear_missed), .q(q_a), .busy(busy_a), .missed(missed_a)
  );

  monoflop_sync_multi #(.COUNT_BITS(2), .RETRIGGER(1)) dut_r (
    .clock(clock), .reset_n(reset_n), .trigger(trigger), .enable(enable),
    .edge_mode(edge_mode), .pulse_width(pulse_width), .holdoff(holdoff),
    .clear_missed(clear_missed), .q(q_b), .busy(busy_b), .missed(missed_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Bit k of wave is the trigger level sampled at edge k+1; bit k of each
  // trace is the output seen just after that edge.
  task automatic run_ch(input int ch, input int n, input logic [63:0] wave,
                        output logic [63:0] qt, output logic [63:0] bt,
                        output logic [63:0] qrt, output logic [7:0] oth);
    qt = '0; bt = '0; qrt = '0; oth = '0;
    for (int k = 0; k < n; k++) begin
      trigger[ch] = wave[k];
      tick();
      qt[k]  = q_a[ch];
      bt[k]  = busy_a[ch];
      qrt[k] = q_b[ch];
      oth    = oth | (q_a & ~(8'd1 << ch));
    end
  endtask

  logic [63:0] qt, bt, qrt;
  logic [7:0]  oth;
  logic [63:0] mode_exp [4];

  initial begin
    mode_exp[0] = 64'h4;
    mode_exp[1] = 64'h40;
    mode_exp[2] = 64'h44;
    mode_exp[3] = 64'h0;

    reset_n = 1'b0; trigger = 8'h00; enable = 8'h00; edge_mode = 2'b00;
    pulse_width = 8'd0; holdoff = 8'd0; clear_missed = 1'b0;
    tick(); tick();
    check("rst_q",      64'(q_a),       64'h0);
    check("rst_busy",   64'(busy_a),    64'h0);
    check("rst_missed", 64'(|missed_a), 64'h0);

    // Reset release and latency
    enable = 8'hFF; pulse_width = 8'd4; holdoff = 8'd0;
    reset_n = 1'b1;
    run_ch(0, 10, 64'h3FF, qt, bt, qrt, oth);
    check("lat_q0",     qt,             64'h3C);
    check("lat_busy0",  bt,             64'h3C);
    check("lat_others", 64'(oth),       64'h0);
    check("lat_missed", 64'(|missed_a), 64'h0);

    // Holdoff and miss count
    pulse_width = 8'd2; holdoff = 8'd5;
    run_ch(1, 20, 64'hFFF39, qt, bt, qrt, oth);
    check("hold_q1",    qt,                    64'hC0C);
    check("hold_busy1", bt,                    64'h1FDFC);
    check("hold_miss1", 64'(missed_a[31:16]),  64'h1);

    // Retrigger versus plain miss
    pulse_width = 8'd4; holdoff = 8'd0;
    run_ch(2, 12, 64'hFFD, qt, bt, qrt, oth);
    check("retrig_q2",     qrt,                  64'hFC);
    check("retrig_miss2",  64'(missed_b[5:4]),   64'h0);
    check("noretrig_q2",   qt,                   64'h3C);
    check("noretrig_miss", 64'(missed_a[47:32]), 64'h1);

    // Edge modes
    pulse_width = 8'd1;
    for (int m = 0; m < 4; m++) begin
      edge_mode = 2'(m);
      run_ch(3, 12, 64'h00F, qt, bt, qrt, oth);
      check($sformatf("mode%0d_q3", m), qt, mode_exp[m]);
    end
    check("mode_miss3", 64'(missed_a[63:48]), 64'h0);
    edge_mode = 2'b00;

    // Enable gating
    enable = 8'hEF; pulse_width = 8'd3;
    run_ch(4, 8, 64'hFF, qt, bt, qrt, oth);
    check("dis_q4",    qt,                   64'h0);
    check("dis_miss4", 64'(missed_a[79:64]), 64'h0);
    run_ch(4, 4, 64'h0, qt, bt, qrt, oth);
    enable = 8'hFF;
    run_ch(4, 4, 64'hF, qt, bt, qrt, oth);
    check("en_start_q4", qt, 64'hC);
    enable = 8'hEF;
    run_ch(4, 6, 64'h3F, qt, bt, qrt, oth);
    check("en_drop_q4",    qt, 64'h1);
    check("en_drop_busy4", bt, 64'h1);
    enable = 8'hFF;

    // Zero width
    pulse_width = 8'd0;
    run_ch(5, 6, 64'h3F, qt, bt, qrt, oth);
    check("w0_q5", qt, 64'h4);

    // Saturation and clear priority
    pulse_width = 8'd1; holdoff = 8'd30;
    run_ch(6, 14, 64'h155, qt, bt, qrt, oth);
    check("sat_miss6",   64'(missed_b[13:12]),   64'h3);
    check("unsat_miss6", 64'(missed_a[111:96]),  64'h4);
    trigger[6] = 1'b1;
    tick(); tick();
    clear_missed = 1'b1;
    tick();
    clear_missed = 1'b0;
    check("clr_miss6_r", 64'(missed_b[13:12]), 64'h0);
    check("clr_all_a",   64'(|missed_a),       64'h0);
    trigger[6] = 1'b0;
    tick(); tick();
    trigger[6] = 1'b1;
    tick(); tick(); tick();
    check("inc_after_clr", 64'(missed_b[13:12]), 64'h1);

    // Asynchronous reset mid-pulse
    pulse_width = 8'd10; holdoff = 8'd0;
    run_ch(7, 5, 64'h1F, qt, bt, qrt, oth);
    check("pre_rst_q7", qt, 64'h1C);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_q",      64'(q_a),       64'h0);
    check("arst_busy",   64'(busy_a),    64'h0);
    check("arst_busy_r", 64'(busy_b),    64'h0);
    check("arst_missed", 64'(|missed_a), 64'h0);
    #2;
    reset_n = 1'b1;
    run_ch(7, 16, 64'hFFFF, qt, bt, qrt, oth);
    check("post_rst_q7",    qt, 64'hFFC);
    check("post_rst_busy7", bt, 64'hFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
